// File: rtl/soc_keys_in.sv
// rtl/soc_keys_in.sv - Avalon-MM input port with synchronizer, edge capture and maskable irq (optional debounce: SOC_KEYS_DEBOUNCE_EN)
module soc_keys_in #(
    parameter int WIDTH           = 16,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_irq_mask;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_stable_ext;
    logic [31:0]      w_mask_ext;
    logic [31:0]      w_cap_ext;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    // Upper writedata bits are ignored when WIDTH < 32; the debounce length is only meaningful with the debounce stage.
    assign w_unused = ^{writedata, (DEBOUNCE_CYCLES > 0)};

    assign w_wr = chipselect && !write_n;

    // Two-flop synchronizer for the asynchronous front-panel inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

`ifdef SOC_KEYS_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt;

    // Whole-word debounce: any change of the synchronized word restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= '0;
        end else if (r_cand != r_stable) begin
            if (r_cnt == CNT_LAST) begin
                r_stable <= r_cand;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_stable = r_stable;
`else
    assign w_stable = r_s2;
`endif

    // Select which transitions of the accepted input word count as events.
    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = w_stable & ~r_prev;
            1:       w_edge = ~w_stable & r_prev;
            default: w_edge = w_stable ^ r_prev;
        endcase
    end

    // Write-1-to-clear mask; only active for writes to the capture register.
    always_comb begin
        w_clr = '0;
        if (w_wr && (address == 2'd3)) begin
            w_clr = writedata[WIDTH-1:0];
        end
    end

    // Previous-sample, edge capture and interrupt mask registers; a fresh edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev         <= '0;
            r_edge_capture <= '0;
            r_irq_mask     <= '0;
        end else begin
            r_prev         <= w_stable;
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge;
            if (w_wr && (address == 2'd2)) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Zero-extend the WIDTH-bit registers onto the 32-bit read bus.
    always_comb begin
        w_stable_ext              = '0;
        w_mask_ext                = '0;
        w_cap_ext                 = '0;
        w_stable_ext[WIDTH-1:0]   = w_stable;
        w_mask_ext[WIDTH-1:0]     = r_irq_mask;
        w_cap_ext[WIDTH-1:0]      = r_edge_capture;
    end

    // Read mux over the current register values.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux = w_stable_ext;
            2'd2:    w_rd_mux = w_mask_ext;
            2'd3:    w_rd_mux = w_cap_ext;
            default: w_rd_mux = '0;
        endcase
    end

    // Read data is registered every cycle, independent of chipselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_soc_keys_in.sv
// tb/tb_soc_keys_in.sv - randomized and directed bench for soc_keys_in against a behavioural model
module tb_soc_keys_in;

    localparam int W = 16;
    localparam int D = 8;
`ifdef SOC_KEYS_DEBOUNCE_EN
    localparam int LAT = D + 3;
    localparam int CHG = 24;
`else
    localparam int LAT = 2;
    localparam int CHG = 3;
`endif
    localparam int SETTLE = LAT + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   rd_q [0:2];
    logic [2:0]    irq_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        soc_keys_in #(
            .WIDTH(W),
            .EDGE_TYPE(g),
            .DEBOUNCE_CYCLES(D)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .address(address),
            .chipselect(chipselect),
            .write_n(write_n),
            .writedata(writedata),
            .in_port(in_port),
            .readdata(rd_q[g]),
            .irq(irq_v[g])
        );
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_s1, m_s2, m_stable, m_prev, n_stable, clr;
    logic [W-1:0] m_cap [0:2];
    logic [W-1:0] m_mask [0:2];
    logic [31:0]  m_rd [0:2];
    logic [W-1:0] m_hist [$];
    bit           m_valid = 1'b0;
    bit           same;

    function automatic logic [W-1:0] events_of(int t, logic [W-1:0] was, logic [W-1:0] now);
        logic [W-1:0] r;
        r = '0;
        for (int b = 0; b < W; b++) begin
            if (was[b] != now[b]) begin
                if (t == 2 || (t == 0 && now[b]) || (t == 1 && !now[b])) r[b] = 1'b1;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
            for (int g = 0; g < 3; g++) begin
                m_cap[g] = '0; m_mask[g] = '0; m_rd[g] = '0;
            end
            m_hist.delete();
            for (int i = 0; i < D + 1; i++) m_hist.push_back('0);
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int g = 0; g < 3; g++) begin
                case (address)
                    2'd0:    m_rd[g] = 32'(m_stable);
                    2'd2:    m_rd[g] = 32'(m_mask[g]);
                    2'd3:    m_rd[g] = 32'(m_cap[g]);
                    default: m_rd[g] = 32'd0;
                endcase
            end
`ifdef SOC_KEYS_DEBOUNCE_EN
            // Accept a word only once it has been seen unchanged for D+1 consecutive cycles.
            m_hist.push_back(m_s2);
            void'(m_hist.pop_front());
            same = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) same = 1'b0;
            n_stable = same ? m_hist[0] : m_stable;
`else
            n_stable = m_s1;
`endif
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            for (int g = 0; g < 3; g++) begin
                m_cap[g] = (m_cap[g] & ~clr) | events_of(g, m_prev, m_stable);
                if (chipselect && !write_n && address == 2'd2) m_mask[g] = writedata[W-1:0];
            end
            m_prev   = m_stable;
            m_stable = n_stable;
            m_s2     = m_s1;
            m_s1     = in_port;
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(posedge clk) begin
        #2;
        if (m_valid) begin
            for (int g = 0; g < 3; g++) begin
                chk("model_readdata", g, rd_q[g], m_rd[g]);
                chk("model_irq", g, 32'(irq_v[g]), 32'(|(m_cap[g] & m_mask[g])));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(logic [W-1:0] v);
        @(negedge clk);
        in_port = v;
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd3(logic [1:0] a, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, string name);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(posedge clk);
        #1;
        chk(name, 0, rd_q[0], e0);
        chk(name, 1, rd_q[1], e1);
        chk(name, 2, rd_q[2], e2);
    endtask

    task automatic irq3(logic e0, logic e1, logic e2, string name);
        chk(name, 0, 32'(irq_v[0]), 32'(e0));
        chk(name, 1, 32'(irq_v[1]), 32'(e1));
        chk(name, 2, 32'(irq_v[2]), 32'(e2));
    endtask

    initial begin
        tick(2);
        reset = 1'b0;

        rd3(2'd0, 32'h0, 32'h0, 32'h0, "reset_data");
        rd3(2'd1, 32'h0, 32'h0, 32'h0, "reset_rsvd");
        rd3(2'd2, 32'h0, 32'h0, 32'h0, "reset_mask");
        rd3(2'd3, 32'h0, 32'h0, 32'h0, "reset_cap");
        irq3(1'b0, 1'b0, 1'b0, "reset_irq");

        set_in(16'hA5C3);
        tick(SETTLE);
        rd3(2'd0, 32'h0000A5C3, 32'h0000A5C3, 32'h0000A5C3, "data_read");
        wr(2'd0, 32'hFFFFFFFF);
        wr(2'd1, 32'hFFFFFFFF);
        rd3(2'd0, 32'h0000A5C3, 32'h0000A5C3, 32'h0000A5C3, "data_ro");
        rd3(2'd1, 32'h0, 32'h0, 32'h0, "rsvd_ro");

        set_in(16'h0000);
        tick(SETTLE);
        wr(2'd3, 32'hFFFFFFFF);
        wr(2'd2, 32'hFFFF0001);
        rd3(2'd2, 32'h1, 32'h1, 32'h1, "mask_width");
        rd3(2'd3, 32'h0, 32'h0, 32'h0, "cap_clear");

        set_in(16'h0001);
        for (int m = 0; m < LAT; m++) begin
            @(posedge clk);
            #1;
            chk("irq_before_latency", 0, 32'(irq_v[0]), 32'h0);
        end
        @(posedge clk);
        #1;
        chk("irq_at_latency", 0, 32'(irq_v[0]), 32'h1);
        rd3(2'd3, 32'h1, 32'h0, 32'h1, "cap_bit0");
        irq3(1'b1, 1'b0, 1'b1, "irq_bit0");

        set_in(16'h0011);
        tick(SETTLE);
        rd3(2'd3, 32'h11, 32'h0, 32'h11, "cap_bit4");
        irq3(1'b1, 1'b0, 1'b1, "irq_bit4");
        wr(2'd3, 32'h00000001);
        rd3(2'd3, 32'h10, 32'h0, 32'h10, "cap_w1c");
        irq3(1'b0, 1'b0, 1'b0, "irq_w1c");

        wr(2'd3, 32'hFFFFFFFF);
        set_in(16'h0015);
        tick(LAT);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h4;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        tick(SETTLE);
        rd3(2'd3, 32'h4, 32'h0, 32'h4, "edge_beats_clear");

        set_in(16'h0080);
        tick(SETTLE);
        wr(2'd3, 32'hFFFFFFFF);
        set_in(16'h0000);
        tick(SETTLE);
        rd3(2'd3, 32'h0, 32'h80, 32'h80, "fall_bit7");
        wr(2'd3, 32'hFFFFFFFF);
        set_in(16'h0080);
        tick(SETTLE);
        rd3(2'd3, 32'h80, 32'h0, 32'h80, "rise_bit7");

`ifdef SOC_KEYS_DEBOUNCE_EN
        set_in(16'h0000);
        tick(SETTLE);
        wr(2'd3, 32'hFFFFFFFF);
        set_in(16'h0001);
        tick(4);
        set_in(16'h0000);
        tick(SETTLE);
        rd3(2'd0, 32'h0, 32'h0, 32'h0, "glitch_data");
        rd3(2'd3, 32'h0, 32'h0, 32'h0, "glitch_cap");
        set_in(16'h0001);
        tick(20);
        rd3(2'd0, 32'h1, 32'h1, 32'h1, "long_data");
        rd3(2'd3, 32'h1, 32'h0, 32'h1, "long_cap");
        set_in(16'h0000);
        tick(SETTLE);
        wr(2'd3, 32'hFFFFFFFF);
        set_in(16'h0001);
        tick(6);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rd3(2'd0, 32'h0, 32'h0, 32'h0, "midcount_reset_data");
        tick(SETTLE);
        rd3(2'd0, 32'h1, 32'h1, 32'h1, "after_reset_data");
        rd3(2'd3, 32'h1, 32'h0, 32'h1, "after_reset_cap");
`endif

        @(negedge clk);
        in_port = 16'h0003;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rd3(2'd3, 32'h0, 32'h0, 32'h0, "post_reset_cap0");
        tick(SETTLE);
        rd3(2'd3, 32'h3, 32'h0, 32'h3, "post_reset_edge");

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, CHG) == 0) begin
                if ($urandom_range(0, 1) == 0) in_port = W'($urandom);
                else in_port = in_port ^ (W'(1) << $urandom_range(0, W - 1));
            end
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            reset      = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        chipselect = 1'b0;
        tick(4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
